// File: rtl/lcd_bus_receiver_if.sv
// rtl/lcd_bus_receiver_if.sv - HD44780-style parallel bus between display driver and receiver
interface lcd_bus_receiver_if;
  logic       RS;
  logic       RW;
  logic       E;
  logic [7:0] DB;
  logic [7:0] DB_out;
  logic       DB_oe;

  modport master (output RS, RW, E, DB, input DB_out, DB_oe);
  modport slave  (input RS, RW, E, DB, output DB_out, DB_oe);
endinterface

// File: rtl/lcd_bus_receiver.sv
// rtl/lcd_bus_receiver.sv - character LCD controller model: decodes bus writes into a 2x16 DDRAM
module lcd_bus_receiver #(
  parameter int BUSY_CYCLES       = 2000,
  parameter int CLEAR_BUSY_CYCLES = 82000
) (
  input  logic                clock50MHz,
  input  logic                reset,
  lcd_bus_receiver_if.slave   bus,
  input  logic [4:0]          rd_addr,
  output logic [7:0]          rd_data,
  output logic [4:0]          cursor,
  output logic                display_on,
  output logic                busy,
  output logic                wr_strobe,
  output logic                protocol_err
);
  localparam int MAXC = (CLEAR_BUSY_CYCLES > BUSY_CYCLES) ? CLEAR_BUSY_CYCLES : BUSY_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR, WAIT} state_t;
  state_t state, state_nx;

  logic          rs_s1, rs_s2, rw_s1, rw_s2, e_s1, e_s2, e_s3;
  logic [7:0]    db_s1, db_s2;
  logic          e_fall, wr_accept, id;
  logic          cmd_clear, cmd_long;
  logic [4:0]    fill_idx;
  logic [CW-1:0] cnt;
  logic [7:0]    ddram [32];

  always_ff @(posedge clock50MHz) begin
    if (reset) begin
      {rs_s1, rs_s2, rw_s1, rw_s2, e_s1, e_s2, e_s3} <= '0;
      db_s1 <= '0;
      db_s2 <= '0;
    end else begin
      rs_s1 <= bus.RS;  rs_s2 <= rs_s1;
      rw_s1 <= bus.RW;  rw_s2 <= rw_s1;
      e_s1  <= bus.E;   e_s2  <= e_s1;  e_s3 <= e_s2;
      db_s1 <= bus.DB;  db_s2 <= db_s1;
    end
  end

  assign e_fall    = e_s3 & ~e_s2;
  assign busy      = (state != IDLE);
  assign wr_accept = e_fall & ~rw_s2 & ~busy;

  always_ff @(posedge clock50MHz) begin
    if (reset) state <= CLEAR;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (wr_accept) state_nx = EXEC;
      EXEC:    state_nx = cmd_clear ? CLEAR : WAIT;
      CLEAR:   if (fill_idx == 5'd31) state_nx = WAIT;
      WAIT:    if (cnt <= CW'(1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock50MHz) begin
    if (reset) begin
      cursor       <= '0;
      id           <= 1'b1;
      display_on   <= 1'b0;
      protocol_err <= 1'b0;
      wr_strobe    <= 1'b0;
      cmd_clear    <= 1'b0;
      cmd_long     <= 1'b0;
      fill_idx     <= '0;
      cnt          <= CW'(CLEAR_BUSY_CYCLES - 1);
      bus.DB_oe    <= 1'b0;
      bus.DB_out   <= '0;
    end else begin
      wr_strobe <= wr_accept;
      bus.DB_oe <= rw_s2 & e_s2;
      if (rw_s2 & e_s2) bus.DB_out <= rs_s2 ? ddram[cursor] : {busy, 2'b00, cursor};
      else              bus.DB_out <= '0;

      if (e_fall & ~rw_s2 & busy) protocol_err <= 1'b1;
      // data reads auto-advance the cursor and are allowed in any state
      if (e_fall & rw_s2 & rs_s2) cursor <= id ? cursor + 5'd1 : cursor - 5'd1;

      if (wr_accept) begin
        cmd_clear <= 1'b0;
        cmd_long  <= 1'b0;
        if (rs_s2) begin
          cursor <= id ? cursor + 5'd1 : cursor - 5'd1;
        end else begin
          casez (db_s2)
            8'b1???????: begin
              cursor <= {db_s2[6], db_s2[3:0]};
              if (db_s2[5:4] != 2'b00) protocol_err <= 1'b1;
            end
            8'b01??????: protocol_err <= 1'b1;
            8'b001?????: if (!db_s2[4]) protocol_err <= 1'b1;
            8'b0001????: ;
            8'b00001???: display_on <= db_s2[2];
            8'b000001??: begin
              id <= db_s2[1];
              if (db_s2[0]) protocol_err <= 1'b1;
            end
            8'b0000001?: begin
              cursor   <= '0;
              cmd_long <= 1'b1;
            end
            8'b00000001: begin
              cursor    <= '0;
              id        <= 1'b1;
              cmd_clear <= 1'b1;
              cmd_long  <= 1'b1;
            end
            default: ;
          endcase
        end
      end

      case (state)
        EXEC: begin
          cnt      <= cmd_long ? CW'(CLEAR_BUSY_CYCLES - 1) : CW'(BUSY_CYCLES - 1);
          fill_idx <= '0;
        end
        CLEAR: begin
          cnt      <= cnt - CW'(1);
          fill_idx <= fill_idx + 5'd1;
        end
        WAIT:    cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // single write port; the registered read returns the pre-write value on a collision
  always_ff @(posedge clock50MHz) begin
    rd_data <= ddram[rd_addr];
    if (!reset) begin
      if (state == CLEAR)         ddram[fill_idx] <= 8'h20;
      else if (wr_accept & rs_s2) ddram[cursor]   <= db_s2;
    end
  end
endmodule

// File: doc/lcd_bus_receiver.md
LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

Interface
REQ-001 Parameter BUSY_CYCLES, default 2000: busy duration after any accepted instruction or data write (40 us at 50 MHz).
REQ-002 Parameter CLEAR_BUSY_CYCLES, default 82000: busy duration after Clear Display or Return Home (1.64 ms).
REQ-003 clock50MHz  in  1  sole clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 RS  in  1  register select from the display driver (0 = instruction, 1 = data).
REQ-006 RW  in  1  0 = write, 1 = read.
REQ-007 E  in  1  enable strobe; a transfer completes on its falling edge.
REQ-008 DB  in  8  data bus from the driver.
REQ-009 DB_out  out  8  read-back value; DB_oe  out  1  high while RW=1 and E=1 (synchronized).
REQ-010 rd_addr  in  5  character-RAM read index, 0-15 line 1, 16-31 line 2; rd_data  out  8  registered, 1-cycle latency.
REQ-011 cursor  out  5  current DDRAM index; display_on  out  1; busy  out  1; wr_strobe  out  1 (one-cycle pulse per executed transfer); protocol_err  out  1 (sticky).

Function
REQ-012 RS, RW, E and DB SHALL pass through a 2-flop synchronizer; falling edge = synchronized E 1 then 0.
REQ-013 An executed transfer SHALL take effect, and wr_strobe pulse, exactly 1 cycle after falling-edge detection (3 cycles after E falls at the pin).
REQ-014 FSM states: IDLE, EXEC, CLEAR, WAIT; IDLE -> EXEC on edge with RW=0; EXEC -> CLEAR for Clear Display, else WAIT; CLEAR -> WAIT after 32 fill cycles; WAIT -> IDLE when busy counter reaches 0.
REQ-015 busy SHALL be high in every state except IDLE; the busy counter loads BUSY_CYCLES-1 or CLEAR_BUSY_CYCLES-1 in EXEC and decrements once per cycle in CLEAR and WAIT.
REQ-016 A write edge while busy=1 SHALL be ignored (no state change, no wr_strobe) and SHALL set protocol_err.
REQ-017 Data write (RS=1): DDRAM[cursor] <= DB, then cursor moves per entry-mode I/D.
REQ-018 Increment wraps 15->16 and 31->0; decrement wraps 16->15 and 0->31.
REQ-019 0x01 Clear: all 32 entries <= 0x20, one per cycle in CLEAR; cursor <= 0; I/D <= 1.
REQ-020 0x02/0x03 Return Home: cursor <= 0, DDRAM unchanged.
REQ-021 0x04-0x07 Entry Mode: I/D <= DB[1]; DB[0]=1 (display shift) SHALL set protocol_err, otherwise ignored.
REQ-022 0x08-0x0F Display Control: display_on <= DB[2]; cursor/blink bits ignored.
REQ-023 0x10-0x1F Shift: accepted with no effect.
REQ-024 0x20-0x3F Function Set: DB[4]=0 (4-bit mode) SHALL set protocol_err; other bits ignored.
REQ-025 0x40-0x7F Set CGRAM address: accepted with no effect; sets protocol_err.
REQ-026 0x80-0xFF Set DDRAM address: cursor <= {DB[6], DB[3:0]}; if DB[5:4] != 0, set protocol_err.
REQ-027 Read with RS=0: DB_out = {busy, 2'b00, cursor}; read with RS=1: DB_out = DDRAM[cursor], and on the E falling edge cursor advances per I/D with no busy period; reads are legal while busy.
REQ-028 A simultaneous rd_addr read and DDRAM write to the same index SHALL return the old value.

Reset
REQ-029 On reset: cursor=0, I/D=1, display_on=0, protocol_err=0, wr_strobe=0, DB_oe=0, DB_out=0, synchronizers cleared.
REQ-030 After reset the FSM SHALL enter CLEAR (busy=1) and fill DDRAM with 0x20, then go to WAIT with CLEAR_BUSY_CYCLES.
REQ-031 Reset asserted mid-CLEAR or mid-WAIT SHALL abort the operation and restart the REQ-030 sequence.

Verification
REQ-032 Reset, wait for busy=0 -> all rd_data = 0x20, cursor=0, display_on=0.
REQ-033 Write instr 0x0C, then data 0x41 ('A') -> display_on=1, DDRAM[0]=0x41, cursor=1, busy high for BUSY_CYCLES.
REQ-034 Set DDRAM 0x8F, write 0x42 -> DDRAM[15]=0x42, cursor=16; set 0xCF, write 0x43 -> DDRAM[31]=0x43, cursor=0.
REQ-035 Write 0x41 immediately after a prior write (busy=1) -> no DDRAM change, protocol_err=1.
REQ-036 Entry mode 0x04, cursor 0, write 0x5A -> DDRAM[0]=0x5A, cursor=31.
REQ-037 Read RS=0 during a clear -> DB_out[7]=1; after clear -> DB_out=0x00.
